// File: rtl/ps2_rx_frame_pkg.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame_pkg
//   Shared definitions for the PS/2 device-to-host frame receiver:
//   FSM state encoding, frame geometry and a parity helper.
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_rx_frame_pkg;

  // Receiver FSM states (explicit 2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a start bit
    ST_DPS  = 2'd1,  // shifting data, parity and stop bits
    ST_LOAD = 2'd2   // one-cycle frame check
  } state_e;

  localparam int FRAME_BITS   = 11;              // start + 8 data + parity + stop
  localparam int DATA_BITS    = 8;
  localparam int PAYLOAD_BITS = FRAME_BITS - 1;  // bits captured after the start bit

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS:0] data_par);
    return ^data_par;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ---------------------------------------------------------------------------
// ps2_clk_filter
//   Conditions the raw PS/2 lines: 2-FF synchronisers on ps2c and ps2d, a
//   FILTER_LEN-deep level filter on ps2c, and a one-cycle falling-edge pulse
//   of the filtered clock. The synchronised data line is delayed by one
//   extra stage so it lines up with the filter output.
//
//   Ports:
//     clk        system clock
//     rst        asynchronous active-low reset
//     ps2c       raw PS/2 clock line
//     ps2d       raw PS/2 data line
//     fall_edge  one-cycle pulse on a filtered ps2c 1->0 transition
//     ps2d_s     synchronised ps2d, valid to sample while fall_edge is high
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_clk_filter
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall_edge,
  output logic ps2d_s
);

  logic                  c_meta_q, c_sync_q;
  logic                  d_meta_q, d_sync_q, d_dly_q;
  logic [FILTER_LEN-1:0] sr_q, sr_d;
  logic                  filt_c_q, filt_c_d;

  // Everything resets to the idle-bus level (high) so that leaving reset
  // never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      d_dly_q  <= 1'b1;
      sr_q     <= '1;
      filt_c_q <= 1'b1;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
      d_dly_q  <= d_sync_q;
      sr_q     <= sr_d;
      filt_c_q <= filt_c_d;
    end
  end

  always_comb begin
    sr_d = {sr_q[FILTER_LEN-2:0], c_sync_q};
    // Level changes only after FILTER_LEN identical samples; mixed history holds.
    if (&sr_q) begin
      filt_c_d = 1'b1;
    end else if (~|sr_q) begin
      filt_c_d = 1'b0;
    end else begin
      filt_c_d = filt_c_q;
    end
  end

  assign fall_edge = filt_c_q & ~filt_c_d;
  assign ps2d_s    = d_dly_q;

endmodule

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
//   PS/2 keyboard receiver. Deframes 11-bit device-to-host frames (start,
//   8 data LSB first, odd parity, stop) and presents each good byte with a
//   one-cycle tick. Bad parity, bad stop bit and inter-edge timeout are
//   reported as one-cycle error pulses.
//
//   Ports:
//     clk           system clock
//     rst           asynchronous active-low reset
//     rx_en         allows a new start bit to be accepted
//     ps2c, ps2d    raw PS/2 clock and data lines
//     dout          last correctly received byte
//     rx_done_tick  one-cycle pulse, dout is new
//     parity_err    one-cycle pulse, frame had bad parity
//     frame_err     one-cycle pulse, bad stop bit or timeout
//     busy          frame in progress
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The abort fires in the cycle the timer would reach TIMEOUT_CYC-1.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 2);
  localparam logic [3:0]    N_START    = 4'(PAYLOAD_BITS - 1);

  logic fall_edge;
  logic ps2d_s;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .fall_edge (fall_edge),
    .ps2d_s    (ps2d_s)
  );

  state_e                  state_q, state_d;
  logic [3:0]              n_q, n_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [PAYLOAD_BITS-1:0] b_q, b_d;
  logic [DATA_BITS-1:0]    dout_q, dout_d;
  logic                    done_q, done_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      timer_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      timer_q <= timer_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    timer_d = timer_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        // rx_en only gates the acceptance of a start bit.
        if (fall_edge && rx_en && !ps2d_s) begin
          state_d = ST_DPS;
          n_d     = N_START;
          timer_d = '0;
        end
      end
      ST_DPS: begin
        if (fall_edge) begin
          b_d     = {ps2d_s, b_q[PAYLOAD_BITS-1:1]};
          timer_d = '0;
          if (n_q == 4'd0) begin
            state_d = ST_LOAD;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: tick values are registered, so each is visible one cycle
  // after the decision. Only one branch can fire per cycle.
  always_comb begin
    done_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    dout_d = dout_q;
    case (state_q)
      ST_DPS: begin
        if (!fall_edge && timer_q == TIMER_LAST) begin
          ferr_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!b_q[DATA_BITS+1]) begin
          ferr_d = 1'b1;
        end else if (!odd_parity_ok(b_q[DATA_BITS:0])) begin
          perr_d = 1'b1;
        end else begin
          done_d = 1'b1;
          dout_d = b_q[DATA_BITS-1:0];
        end
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;

endmodule

`default_nettype wire
